// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU load/store port has fixed priority over the VGA fetcher,
// with a starvation guard. Optional stats counters are enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int RD_LAT       = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_q,
    output logic              vga_valid,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_grants,
    output logic [15:0]       stat_vga_grants,
    output logic [15:0]       stat_cpu_stalls
`endif
);

    // Counter keeps at least one bit so STARVE_LIMIT=0 (VGA always wins) stays legal.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VGA = 1'b1
    } owner_t;

    logic             grant_vga;
    logic             grant_cpu;
    logic [CNT_W-1:0] starve_cnt;
    logic [RD_LAT-1:0] tag_valid;
    owner_t           tag_owner [RD_LAT];

    always_comb begin
        grant_vga = ~reset & vga_req & (~cpu_req | (starve_cnt >= LIMIT));
        grant_cpu = ~reset & cpu_req & ~grant_vga;
    end

    assign vga_ack    = grant_vga;
    assign cpu_stall  = cpu_req & grant_vga;
    assign ram_addr   = grant_vga ? vga_addr : cpu_addr;
    assign ram_wEn    = grant_cpu & cpu_wren;
    assign ram_dataIn = cpu_data;

    assign cpu_q      = ram_dataOut;
    assign vga_q      = ram_dataOut;
    assign cpu_rvalid = tag_valid[RD_LAT-1] & (tag_owner[RD_LAT-1] == OWN_CPU);
    assign vga_valid  = tag_valid[RD_LAT-1] & (tag_owner[RD_LAT-1] == OWN_VGA);

    always_ff @(posedge clock) begin
        if (reset || grant_vga || !vga_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Tag pipe tracks who owns the read data emerging from the RAM RD_LAT cycles later.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_owner[i] <= OWN_CPU;
            end
        end else begin
            tag_valid[0] <= (grant_cpu & ~cpu_wren) | grant_vga;
            tag_owner[0] <= grant_vga ? OWN_VGA : OWN_CPU;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_cpu_grants <= '0;
            stat_vga_grants <= '0;
            stat_cpu_stalls <= '0;
        end else begin
            if (grant_cpu && stat_cpu_grants != '1) begin
                stat_cpu_grants <= stat_cpu_grants + 16'd1;
            end
            if (grant_vga && stat_vga_grants != '1) begin
                stat_vga_grants <= stat_vga_grants + 16'd1;
            end
            if (cpu_stall && stat_cpu_stalls != '1) begin
                stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle RAM and a read-return scoreboard.
module tb_dmem_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_wren, vga_req;
    logic [AW-1:0] cpu_addr, vga_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_stall, cpu_rvalid, vga_ack, vga_valid, ram_wEn;
    logic [DW-1:0] cpu_q, vga_q, ram_dataIn, ram_dataOut;
    logic [AW-1:0] ram_addr;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_cpu_grants, stat_vga_grants, stat_cpu_stalls;
`endif

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .RD_LAT(1)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_stall(cpu_stall), .cpu_q(cpu_q), .cpu_rvalid(cpu_rvalid),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .vga_q(vga_q), .vga_valid(vga_valid),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_grants(stat_cpu_grants),
        .stat_vga_grants(stat_vga_grants),
        .stat_cpu_stalls(stat_cpu_stalls)
`endif
    );

    // Behavioural synchronous-read RAM (read-before-write).
    logic [DW-1:0] ram [1 << AW];
    always @(posedge clock) begin
        if (ram_wEn) ram[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram[ram_addr];
    end

    typedef struct {
        logic          cpu;
        logic          vga;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          sb [$];
    logic [DW-1:0] ref_mem [1 << AW];
    int unsigned   m_starve;
    int unsigned   m_cg, m_vg, m_st;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: check returns due now, drive inputs, check grant outputs, predict next return.
    task automatic step(input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic vr, input logic [AW-1:0] va);
        ret_t          e;
        logic          gv, gc;
        logic [AW-1:0] a;
        @(negedge clock);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, e.cpu});
            chk("vga_valid", {31'b0, vga_valid}, {31'b0, e.vga});
            if (e.cpu) chk("cpu_q", cpu_q, e.data);
            if (e.vga) chk("vga_q", vga_q, e.data);
        end
        reset = r; cpu_req = cr; cpu_wren = cw; cpu_addr = ca; cpu_data = cd;
        vga_req = vr; vga_addr = va;
        #1;
        gv = !r && vr && (!cr || m_starve >= LIMIT);
        gc = !r && cr && !gv;
        a  = gv ? va : ca;
        chk("vga_ack", {31'b0, vga_ack}, {31'b0, gv});
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cr && gv});
        chk("ram_wEn", {31'b0, ram_wEn}, {31'b0, gc && cw});
        chk("ram_addr", {20'b0, ram_addr}, {20'b0, a});
        chk("ram_dataIn", ram_dataIn, cd);
        e.cpu  = gc && !cw;
        e.vga  = gv;
        e.data = ref_mem[a];
        sb.push_back(e);
        if (gc && cw) ref_mem[ca] = cd;
        if (r || gv || !vr) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (r) begin
            m_cg = 0; m_vg = 0; m_st = 0;
        end else begin
            if (gc && m_cg < 16'hFFFF) m_cg++;
            if (gv && m_vg < 16'hFFFF) m_vg++;
            if (cr && gv && m_st < 16'hFFFF) m_st++;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
            ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
        end
        m_starve = 0; m_cg = 0; m_vg = 0; m_st = 0;

        step(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
        step(1'b1, 1'b1, 1'b1, 12'h3, 32'h1, 1'b1, 12'h7);
        idle();
        idle();

        // CPU only: write then read back
        step(1'b0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 12'h0);
        step(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h0);
        idle();

        // VGA only
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h800);
        idle();

        // Contention: reads, then writes (stall cycles must not write)
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 12'h020, 32'h0, 1'b1, 12'h801);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 12'h030 + 12'(i), 32'h1000 + 32'(i), 1'b1, 12'h802);
        idle();
        step(1'b0, 1'b1, 1'b0, 12'h033, 32'h0, 1'b0, 12'h0);
        step(1'b0, 1'b1, 1'b0, 12'h034, 32'h0, 1'b0, 12'h0);

        // Interleave: CPU read then VGA read
        step(1'b0, 1'b1, 1'b0, 12'h004, 32'h0, 1'b0, 12'h0);
        step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h005);
        idle();
        idle();

        // Reset mid-flight, then contention restarts the starvation count
        step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h806);
        step(1'b1, 1'b1, 1'b1, 12'h040, 32'hCAFE0001, 1'b1, 12'h807);
        idle();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 12'h041, 32'h0, 1'b1, 12'h808);

`ifdef DMEM_ARB_STATS_EN
        @(negedge clock);
        chk("stat_cpu_grants", {16'b0, stat_cpu_grants}, 32'(m_cg));
        chk("stat_vga_grants", {16'b0, stat_vga_grants}, 32'(m_vg));
        chk("stat_cpu_stalls", {16'b0, stat_cpu_stalls}, 32'(m_st));
`endif
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
